// File: rtl/l1_bus_arbiter.sv
// Round-robin owner selection for the shared L1 cache bus. Runs one memory fetch
// at a time and returns {ID, data} (or a timeout error) to the owning cache.
module l1_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    bus_start,
    input  logic [NUM_REQ*12-1:0] bus_out_flat,
    output logic [11:0]           bus_in,
    output logic [NUM_REQ-1:0]    bus_done,
    output logic                  bus_err,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  mem_req,
    output logic [ID_W-1:0]       mem_id,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  busy
);
    localparam int BUS_W = 12;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_RELEASE} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BUS_W-1:0]   bus_in_q, bus_in_d;
    logic [NUM_REQ-1:0] bus_done_q, bus_done_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               bus_err_q, bus_err_d;
    logic               mem_req_q, mem_req_d;
    logic               busy_q, busy_d;
    logic [ID_W-1:0]    mem_id_q, mem_id_d;

    logic [NUM_REQ-1:0][ID_W-1:0] req_id;
    logic                         sel_found;
    logic [IDX_W-1:0]             sel_idx;
    logic [IDX_W-1:0]             cand;
    logic                         unused_bus_out;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_id
        assign req_id[k] = bus_out_flat[BUS_W*k + BUS_W-1 -: ID_W];
    end
    // The address/payload half of each cache bus_out is not needed here.
    assign unused_bus_out = ^bus_out_flat;

    // First active requester scanning last+1, last+2, ... with wraparound.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
            if (!sel_found && bus_start[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        bus_in_d   = bus_in_q;
        bus_done_d = bus_done_q;
        grant_d    = grant_q;
        bus_err_d  = bus_err_q;
        mem_req_d  = mem_req_q;
        mem_id_d   = mem_id_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    grant_d   = NUM_REQ'(1) << sel_idx;
                    mem_id_d  = req_id[sel_idx];
                    mem_req_d = 1'b1;
                    last_d    = sel_idx;
                    cnt_d     = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // An ack in the final counted cycle still beats the timeout.
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    bus_in_d   = BUS_W'({mem_id_q, mem_data});
                    bus_done_d = NUM_REQ'(1) << last_q;
                    bus_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    mem_req_d  = 1'b0;
                    bus_in_d   = BUS_W'({mem_id_q, {DATA_W{1'b0}}});
                    bus_done_d = NUM_REQ'(1) << last_q;
                    bus_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                bus_done_d = '0;
                bus_err_d  = 1'b0;
                state_d    = S_RELEASE;
            end
            default: begin
                if (!bus_start[last_q]) begin
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= IDX_W'(NUM_REQ - 1);
            cnt_q      <= '0;
            bus_in_q   <= '0;
            bus_done_q <= '0;
            grant_q    <= '0;
            bus_err_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_id_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            bus_in_q   <= bus_in_d;
            bus_done_q <= bus_done_d;
            grant_q    <= grant_d;
            bus_err_q  <= bus_err_d;
            mem_req_q  <= mem_req_d;
            mem_id_q   <= mem_id_d;
            busy_q     <= busy_d;
        end
    end

    assign bus_in   = bus_in_q;
    assign bus_done = bus_done_q;
    assign bus_err  = bus_err_q;
    assign grant    = grant_q;
    assign mem_req  = mem_req_q;
    assign mem_id   = mem_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// Bench for l1_bus_arbiter: transaction-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_l1_bus_arbiter;
    localparam int NR = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] bus_start;
    logic [NR*12-1:0] bus_out_flat;
    logic [11:0]   bus_in;
    logic [NR-1:0] bus_done;
    logic          bus_err;
    logic [NR-1:0] grant;
    logic          mem_req;
    logic [3:0]    mem_id;
    logic          mem_ack;
    logic [7:0]    mem_data;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    l1_bus_arbiter #(.NUM_REQ(NR), .ID_W(4), .DATA_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus_start(bus_start), .bus_out_flat(bus_out_flat),
        .bus_in(bus_in), .bus_done(bus_done), .bus_err(bus_err), .grant(grant),
        .mem_req(mem_req), .mem_id(mem_id), .mem_ack(mem_ack), .mem_data(mem_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: who owns the bus, whether a fetch is outstanding,
    // how many cycles it has waited, and the done/err pulse.
    int         m_owner, m_last, m_waited, mk;
    bit         m_wait, m_pulse, m_err;
    logic [11:0] m_bus_in;
    logic [3:0]  m_mem_id;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_last = NR - 1; m_waited = 0;
            m_wait = 0; m_pulse = 0; m_err = 0; m_bus_in = '0; m_mem_id = '0;
        end else if (m_owner < 0) begin
            for (int i = 1; i <= NR; i++) begin
                mk = (m_last + i) % NR;
                if (bus_start[mk]) begin
                    m_owner = mk; m_last = mk; m_wait = 1; m_waited = 0;
                    m_mem_id = bus_out_flat[12*mk+8 +: 4];
                    break;
                end
            end
        end else if (m_wait) begin
            m_waited++;
            if (mem_ack) begin
                m_wait = 0; m_pulse = 1; m_err = 0; m_bus_in = {m_mem_id, mem_data};
            end else if (m_waited == TO) begin
                m_wait = 0; m_pulse = 1; m_err = 1; m_bus_in = {m_mem_id, 8'h00};
            end
        end else if (m_pulse) begin
            m_pulse = 0; m_err = 0;
        end else if (!bus_start[m_owner]) begin
            m_owner = -1;
        end
    end

    logic [NR-1:0] e_oh;
    always @(negedge clk) begin
        if (chk_en) begin
            e_oh = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
            chk("grant",    grant,    e_oh);
            chk("bus_done", bus_done, m_pulse ? e_oh : '0);
            chk("bus_err",  bus_err,  m_err);
            chk("bus_in",   bus_in,   m_bus_in);
            chk("mem_req",  mem_req,  m_wait);
            chk("mem_id",   mem_id,   m_mem_id);
            chk("busy",     busy,     m_owner >= 0);
        end
    end

    function automatic int oh2idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_id(input int k, input logic [3:0] id);
        bus_out_flat[12*k +: 12] = {id, 8'h5A};
    endtask

    task automatic wait_req(output int g);
        int n;
        n = 0;
        while (!mem_req && n < 40) begin @(negedge clk); n++; end
        if (!mem_req) chk("wait_req_bound", mem_req, 1);
        g = oh2idx(grant);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus_done == '0 && n < 40) begin @(negedge clk); n++; end
        if (bus_done == '0) chk("wait_done_bound", |bus_done, 1);
    endtask

    task automatic ack(input int delay, input logic [7:0] d);
        repeat (delay) @(negedge clk);
        mem_ack = 1'b1; mem_data = d;
        @(negedge clk);
        mem_ack = 1'b0; mem_data = 8'h00;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int g, n;
        rst = 1'b1; bus_start = '0; bus_out_flat = '0; mem_ack = 1'b0; mem_data = '0;
        step(); chk_en = 1'b1; step();
        chk("rst_grant", grant, 0);
        chk("rst_bus_in", bus_in, 0);
        chk("rst_bus_done", bus_done, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Round-robin with all four requesting
        for (int k = 0; k < NR; k++) set_id(k, 4'(k + 1));
        bus_start = 4'hF;
        for (int t = 0; t < 5; t++) begin
            wait_req(g);
            chk("rr_grant", g, exp_order[t]);
            chk("rr_mem_id", mem_id, exp_order[t] + 1);
            ack(0, 8'(8'h10 + t));
            chk("rr_done_err", bus_err, 0);
            bus_start[g] = 1'b0; step(); step(); bus_start[g] = 1'b1;
        end
        bus_start = '0; step(); step();

        // Single miss from cache 2; ID change after grant is ignored
        set_id(2, 4'h9);
        bus_start = 4'b0100;
        wait_req(g);
        chk("miss_grant", g, 2);
        chk("miss_mem_id", mem_id, 4'h9);
        set_id(2, 4'h3);
        ack(2, 8'hA5);
        chk("miss_bus_in", bus_in, 12'h9A5);
        chk("miss_done", bus_done, 4'b0100);
        chk("miss_err", bus_err, 0);
        step();
        chk("miss_done_drop", bus_done, 0);
        chk("miss_bus_in_hold", bus_in, 12'h9A5);
        bus_start = '0; step(); step();

        // Release hold-off: owner 3 keeps bus_start high two cycles
        set_id(3, 4'hE); set_id(0, 4'h4);
        bus_start = 4'b1001;
        wait_req(g);
        chk("hold_first", g, 3);
        ack(0, 8'h77);
        chk("hold_done", bus_done, 4'b1000);
        step(); chk("hold_grant1", grant, 4'b1000);
        step(); chk("hold_grant2", grant, 4'b1000);
        bus_start[3] = 1'b0;
        wait_req(g);
        chk("hold_next", g, 0);
        chk("hold_next_id", mem_id, 4'h4);
        ack(0, 8'h01);
        step(); bus_start = '0; step(); step();

        // Timeout with no ack
        set_id(1, 4'h6);
        bus_start = 4'b0010;
        wait_req(g);
        chk("to_grant", g, 1);
        wait_done(n);
        chk("to_latency", n, TO);
        chk("to_err", bus_err, 1);
        chk("to_bus_in", bus_in, 12'h600);
        chk("to_done", bus_done, 4'b0010);
        step(); bus_start = '0; step(); step();

        // Ack in the last WAIT cycle wins over the timeout
        set_id(1, 4'hC);
        bus_start = 4'b0010;
        wait_req(g);
        ack(TO - 1, 8'h3C);
        chk("late_done", bus_done, 4'b0010);
        chk("late_err", bus_err, 0);
        chk("late_bus_in", bus_in, 12'hC3C);
        step(); bus_start = '0; step(); step();

        // Reset mid-WAIT, then requester 3 alone
        set_id(0, 4'h2);
        bus_start = 4'b0001;
        wait_req(g);
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_mem_req", mem_req, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        set_id(3, 4'h7);
        bus_start = 4'b1000;
        wait_req(g);
        chk("post_rst_grant", g, 3);
        chk("post_rst_id", mem_id, 4'h7);
        ack(1, 8'h99);
        chk("post_rst_bus_in", bus_in, 12'h799);
        step(); bus_start = '0; step(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
